// File: rtl/video_sync_decoder.sv
// ---------------------------------------------------------------------------
// video_sync_decoder
//
// Receive-side sync decoder. It samples an external hsync/vsync pair on a
// pixel strobe and measures the line period (in pixels) and the frame period
// (in lines). It acquires lock in three steps: horizontal first, then
// vertical, then LOCKED. While locked it regenerates line/frame start pulses.
// Horizontal and vertical position counters run in every state.
//
// Ports
//   I_clock        system clock (only clock domain)
//   I_reset        synchronous reset, active-low
//   I_pixel_en     pixel strobe; the sync inputs are sampled only on these cycles
//   I_hsync        horizontal sync (active level set by P_sync_low)
//   I_vsync        vertical sync   (active level set by P_sync_low)
//   O_locked       high while the decoder is LOCKED
//   O_hcount       pixels since the last hsync assert edge (0 on the edge sample)
//   O_vcount       lines since the last applied vsync (0 on the first line)
//   O_h_total      last accepted line period in pixels
//   O_v_total      last accepted frame period in lines
//   O_line_start   1-cycle pulse on an hsync assert edge, only while locked
//   O_frame_start  1-cycle pulse on the hsync edge that starts line 0, only while locked
//   O_error        1-cycle pulse for each mismatched line/frame or timeout
//
// All outputs are registered. They change on the cycle after a strobed sample.
// ---------------------------------------------------------------------------
module video_sync_decoder #(
  parameter int P_width      = 16,
  parameter int P_lock_lines = 4,
  parameter int P_miss_limit = 2,
  parameter int P_timeout    = 4095,
  parameter int P_sync_low   = 1
) (
  input  logic               I_clock,
  input  logic               I_reset,
  input  logic               I_pixel_en,
  input  logic               I_hsync,
  input  logic               I_vsync,
  output logic               O_locked,
  output logic [P_width-1:0] O_hcount,
  output logic [P_width-1:0] O_vcount,
  output logic [P_width-1:0] O_h_total,
  output logic [P_width-1:0] O_v_total,
  output logic               O_line_start,
  output logic               O_frame_start,
  output logic               O_error
);

  localparam int MATCH_W = (P_lock_lines < 1) ? 1 : $clog2(P_lock_lines + 1);
  localparam int MISS_W  = (P_miss_limit < 1) ? 1 : $clog2(P_miss_limit + 1);

  localparam logic [P_width-1:0] CNT_MAX      = '1;
  // The timeout fires on the strobe that carries h_run from P_timeout-1 to
  // P_timeout. O_hcount therefore reads P_timeout in the same cycle as O_error.
  localparam logic [P_width-1:0] TIMEOUT_LAST = P_width'(P_timeout - 1);
  localparam logic [MATCH_W-1:0] LOCK_LINES   = MATCH_W'(P_lock_lines);
  localparam logic [MISS_W-1:0]  MISS_LIMIT   = MISS_W'(P_miss_limit);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_HMEAS,
    ST_VMEAS,
    ST_LOCKED
  } state_t;

  // Vertical acquisition sub-steps inside VMEAS.
  typedef enum logic [1:0] {
    VS_WAIT,      // waiting for the first applied vsync
    VS_ARMED,     // next applied vsync yields the reference frame period
    VS_HAVE_REF   // next applied vsync is compared against the reference
  } vstage_t;

  state_t               state_reg;
  vstage_t              vstage_reg;
  logic                 h_prev_reg;
  logic                 v_prev_reg;
  logic                 v_pend_reg;
  logic [P_width-1:0]   h_run_reg;
  logic [P_width-1:0]   v_run_reg;
  logic [P_width-1:0]   ref_reg;
  logic                 ref_valid_reg;
  logic [MATCH_W-1:0]   match_reg;
  logic [P_width-1:0]   vref_reg;
  logic [MISS_W-1:0]    miss_reg;

  logic                 h_act;
  logic                 v_act;
  logic                 h_assert;
  logic                 v_assert;
  logic                 apply_v;
  logic [P_width-1:0]   h_inc;
  logic [P_width-1:0]   v_inc;
  logic [MATCH_W-1:0]   match_inc;
  logic [MISS_W-1:0]    miss_inc;
  logic                 line_bad;
  logic                 frame_bad;
  logic                 timeout_hit;

  // Normalise both syncs to "1 = active" so the rest of the logic does not
  // depend on polarity.
  generate
    if (P_sync_low != 0) begin : g_active_low
      assign h_act = ~I_hsync;
      assign v_act = ~I_vsync;
    end else begin : g_active_high
      assign h_act = I_hsync;
      assign v_act = I_vsync;
    end
  endgenerate

  always_comb begin
    h_assert  = I_pixel_en & h_act & ~h_prev_reg;
    v_assert  = I_pixel_en & v_act & ~v_prev_reg;
    // A latched vsync is applied at the next hsync edge. A vsync edge that
    // arrives on the same sample as the hsync edge applies to that same line.
    apply_v   = h_assert & (v_pend_reg | v_assert);
    // Saturating increments. On an hsync edge, h_inc is also the period of
    // the line that just ended, and v_inc is the period of the frame that
    // just ended.
    h_inc     = (h_run_reg == CNT_MAX) ? h_run_reg : h_run_reg + 1'b1;
    v_inc     = (v_run_reg == CNT_MAX) ? v_run_reg : v_run_reg + 1'b1;
    match_inc = match_reg + 1'b1;
    miss_inc  = miss_reg + 1'b1;
    line_bad  = (h_inc != O_h_total);
    frame_bad = apply_v & (v_inc != O_v_total);
    timeout_hit = I_pixel_en & ~h_assert & (h_run_reg == TIMEOUT_LAST) &
                  (state_reg != ST_SEARCH);
  end

  assign O_hcount = h_run_reg;
  assign O_vcount = v_run_reg;

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      state_reg     <= ST_SEARCH;
      vstage_reg    <= VS_WAIT;
      h_prev_reg    <= 1'b0;
      v_prev_reg    <= 1'b0;
      v_pend_reg    <= 1'b0;
      h_run_reg     <= '0;
      v_run_reg     <= '0;
      ref_reg       <= '0;
      ref_valid_reg <= 1'b0;
      match_reg     <= '0;
      vref_reg      <= '0;
      miss_reg      <= '0;
      O_locked      <= 1'b0;
      O_h_total     <= '0;
      O_v_total     <= '0;
      O_line_start  <= 1'b0;
      O_frame_start <= 1'b0;
      O_error       <= 1'b0;
    end else begin
      O_line_start  <= 1'b0;
      O_frame_start <= 1'b0;
      O_error       <= 1'b0;

      if (I_pixel_en) begin
        h_prev_reg <= h_act;
        v_prev_reg <= v_act;

        // Position counters run in every state.
        if (h_assert) begin
          h_run_reg <= '0;
          v_run_reg <= apply_v ? '0 : v_inc;
        end else begin
          h_run_reg <= h_inc;
        end

        if (apply_v) begin
          v_pend_reg <= 1'b0;
        end else if (v_assert) begin
          v_pend_reg <= 1'b1;
        end

        if (timeout_hit) begin
          state_reg <= ST_SEARCH;
          O_locked  <= 1'b0;
          O_error   <= 1'b1;
        end else if (h_assert) begin
          case (state_reg)
            ST_SEARCH: begin
              // The first line seen is partial, so do not use it as a reference.
              state_reg     <= ST_HMEAS;
              ref_valid_reg <= 1'b0;
              match_reg     <= '0;
            end

            ST_HMEAS: begin
              if (ref_valid_reg && (h_inc == ref_reg)) begin
                if (match_inc == LOCK_LINES) begin
                  state_reg  <= ST_VMEAS;
                  vstage_reg <= VS_WAIT;
                  O_h_total  <= ref_reg;
                  match_reg  <= '0;
                end else begin
                  match_reg <= match_inc;
                end
              end else begin
                ref_reg       <= h_inc;
                ref_valid_reg <= 1'b1;
                match_reg     <= '0;
              end
            end

            ST_VMEAS: begin
              if (line_bad) begin
                // The horizontal timing moved. Restart horizontal measurement
                // and use this line's period as the new reference.
                state_reg     <= ST_HMEAS;
                ref_reg       <= h_inc;
                ref_valid_reg <= 1'b1;
                match_reg     <= '0;
              end else if (apply_v) begin
                case (vstage_reg)
                  VS_WAIT: begin
                    vstage_reg <= VS_ARMED;
                  end
                  VS_ARMED: begin
                    vref_reg   <= v_inc;
                    vstage_reg <= VS_HAVE_REF;
                  end
                  VS_HAVE_REF: begin
                    if (v_inc == vref_reg) begin
                      state_reg     <= ST_LOCKED;
                      O_locked      <= 1'b1;
                      O_v_total     <= vref_reg;
                      miss_reg      <= '0;
                      O_line_start  <= 1'b1;
                      O_frame_start <= 1'b1;
                    end else begin
                      vref_reg <= v_inc;
                    end
                  end
                  default: begin
                    vstage_reg <= VS_WAIT;
                  end
                endcase
              end
            end

            ST_LOCKED: begin
              if (line_bad || frame_bad) begin
                O_error <= 1'b1;
                if (miss_inc == MISS_LIMIT) begin
                  // Dropping lock: no start pulses on this edge, so the pulses
                  // never appear while O_locked is low.
                  state_reg <= ST_SEARCH;
                  O_locked  <= 1'b0;
                  miss_reg  <= '0;
                end else begin
                  miss_reg      <= miss_inc;
                  O_line_start  <= 1'b1;
                  O_frame_start <= apply_v;
                end
              end else begin
                miss_reg      <= '0;
                O_line_start  <= 1'b1;
                O_frame_start <= apply_v;
              end
            end

            default: begin
              state_reg <= ST_SEARCH;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_video_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_video_sync_decoder
//
// Scoreboard bench for video_sync_decoder. The driver builds video frames
// (hsync active for pixels 0..7, vsync active for lines 0..2, active-low).
// For every strobe or reset cycle it pushes the hand-derived expected output
// set into a queue. The monitor pops one entry after every strobed or reset
// clock edge and compares it on the falling edge.
// ---------------------------------------------------------------------------
module tb_video_sync_decoder;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_pixel_en;
  logic        I_hsync;
  logic        I_vsync;
  logic        O_locked;
  logic [15:0] O_hcount;
  logic [15:0] O_vcount;
  logic [15:0] O_h_total;
  logic [15:0] O_v_total;
  logic        O_line_start;
  logic        O_frame_start;
  logic        O_error;

  video_sync_decoder dut (
    .I_clock      (I_clock),
    .I_reset      (I_reset),
    .I_pixel_en   (I_pixel_en),
    .I_hsync      (I_hsync),
    .I_vsync      (I_vsync),
    .O_locked     (O_locked),
    .O_hcount     (O_hcount),
    .O_vcount     (O_vcount),
    .O_h_total    (O_h_total),
    .O_v_total    (O_v_total),
    .O_line_start (O_line_start),
    .O_frame_start(O_frame_start),
    .O_error      (O_error)
  );

  always #5 I_clock = ~I_clock;

  typedef struct {
    int hc;
    int vc;
    int ht;
    int vt;
    bit lk;
    bit ls;
    bit fs;
    bit er;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s [%s] got=%0d want=%0d", name, phase, act, want);
    end
  endtask

  // Monitor: any strobed or reset edge produces exactly one output set.
  initial begin
    forever begin
      @(posedge I_clock);
      if (I_pixel_en || !I_reset) begin
        @(negedge I_clock);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow [%s] got=empty want=entry", phase);
        end else begin
          mon_e = sb.pop_front();
          chk("hcount",      int'(O_hcount),      mon_e.hc);
          chk("vcount",      int'(O_vcount),      mon_e.vc);
          chk("h_total",     int'(O_h_total),     mon_e.ht);
          chk("v_total",     int'(O_v_total),     mon_e.vt);
          chk("locked",      int'(O_locked),      int'(mon_e.lk));
          chk("line_start",  int'(O_line_start),  int'(mon_e.ls));
          chk("frame_start", int'(O_frame_start), int'(mon_e.fs));
          chk("error",       int'(O_error),       int'(mon_e.er));
        end
      end
    end
  end

  // One strobe. The gap cycles that follow carry random sync levels, which
  // the decoder must ignore.
  task automatic pix(input bit hact, input bit vact, input int gap, input exp_t e);
    I_hsync    = ~hact;
    I_vsync    = ~vact;
    I_pixel_en = 1'b1;
    sb.push_back(e);
    @(posedge I_clock); #1;
    I_pixel_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      I_hsync = 1'($urandom_range(0, 1));
      I_vsync = 1'($urandom_range(0, 1));
      @(posedge I_clock); #1;
    end
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{hc: 0, vc: 0, ht: 0, vt: 0, lk: 1'b0, ls: 1'b0, fs: 1'b0, er: 1'b0};
    I_reset    = 1'b0;
    I_pixel_en = 1'b0;
    sb.push_back(z);
    @(posedge I_clock); #1;
    I_reset = 1'b1;
    $display("txn reset: checks=%0d errors=%0d", checks, errors);
  endtask

  // One frame of V lines with H pixels each.
  //   short_mask   lines that are one pixel short
  //   jitter       odd lines are one pixel long
  //   lk0/lk_chg   locked state is lk0 and flips from line lk_chg on (-1: never)
  //   ht0/ht_chg/ht1  O_h_total is ht0 and becomes ht1 from line ht_chg on
  //   vt_hold      O_v_total while unlocked (V while locked)
  //   err_mask     lines whose first pixel carries an error pulse
  //   ystop/xstop  stop after emitting this pixel (-1: full frame)
  task automatic gen_frame(input int V, input int H, input int short_mask,
                           input bit jitter, input int gap, input bit lk0,
                           input int lk_chg, input int ht0, input int ht_chg,
                           input int ht1, input int vt_hold, input int err_mask,
                           input int ystop, input int xstop);
    exp_t e;
    int   len;
    bit   lk;
    for (int y = 0; y < V; y++) begin
      len = H - ((short_mask >> y) & 1) + ((jitter && (y % 2 == 1)) ? 1 : 0);
      for (int x = 0; x < len; x++) begin
        lk   = (lk_chg >= 0 && y >= lk_chg) ? ~lk0 : lk0;
        e.hc = x;
        e.vc = y;
        e.lk = lk;
        e.ls = lk && (x == 0);
        e.fs = lk && (x == 0) && (y == 0);
        e.er = (x == 0) && (((err_mask >> y) & 1) == 1);
        e.ht = (ht_chg >= 0 && y >= ht_chg) ? ht1 : ht0;
        e.vt = lk ? V : vt_hold;
        pix(x < 8, y < 3, gap, e);
        if (y == ystop && x == xstop) return;
      end
    end
  endtask

  initial begin
    exp_t e;
    I_reset    = 1'b1;
    I_pixel_en = 1'b0;
    I_hsync    = 1'b1;
    I_vsync    = 1'b1;
    repeat (2) @(posedge I_clock);
    #1;

    phase = "reset";
    do_reset();

    // 341 px/line stream: horizontal lock on line 5, locked at frame 3 start.
    phase = "lock341";
    for (int f = 0; f < 5; f++) begin
      gen_frame(10, 341, 0, 1'b0, 0, f >= 3, -1, (f == 0) ? 0 : 341,
                (f == 0) ? 5 : -1, 341, 0, 0, -1, -1);
      $display("txn %s frame %0d: checks=%0d errors=%0d", phase, f, checks, errors);
    end

    // One short line: a single error, lock held.
    phase = "one_short";
    gen_frame(10, 341, 1 << 4, 1'b0, 0, 1'b1, -1, 341, -1, 341, 10, 1 << 5, -1, -1);
    $display("txn %s: checks=%0d errors=%0d", phase, checks, errors);

    // Two consecutive short lines: unlock at line 5, then reacquire.
    phase = "two_short";
    gen_frame(10, 341, (1 << 3) | (1 << 4), 1'b0, 0, 1'b1, 5, 341, -1, 341, 10,
              (1 << 4) | (1 << 5), -1, -1);
    $display("txn %s: checks=%0d errors=%0d", phase, checks, errors);
    phase = "relock341";
    for (int r = 0; r < 4; r++) begin
      gen_frame(10, 341, 0, 1'b0, 0, r == 3, -1, 341, -1, 341, 10, 0, -1, -1);
      $display("txn %s frame %0d: checks=%0d errors=%0d", phase, r, checks, errors);
    end

    // hsync stuck inactive after the last line: timeout at h_run = 4095.
    phase = "timeout";
    for (int x = 341; x < 4200; x++) begin
      e = '{hc: x, vc: 9, ht: 341, vt: 10, lk: (x < 4095), ls: 1'b0, fs: 1'b0,
            er: (x == 4095)};
      pix(1'b0, 1'b0, 0, e);
    end
    $display("txn %s: checks=%0d errors=%0d", phase, checks, errors);

    // Strobe with 3 idle cycles between pixels: same counts as continuous.
    phase = "gapped";
    do_reset();
    for (int f = 0; f < 5; f++) begin
      gen_frame(8, 40, 0, 1'b0, 3, f >= 3, -1, (f == 0) ? 0 : 40,
                (f == 0) ? 5 : -1, 40, 0, 0, -1, -1);
      $display("txn %s frame %0d: checks=%0d errors=%0d", phase, f, checks, errors);
    end

    // Reset at line 3 pixel 17 of a locked frame, then full reacquisition.
    phase = "midreset";
    gen_frame(8, 40, 0, 1'b0, 0, 1'b1, -1, 40, -1, 40, 0, 0, 3, 17);
    do_reset();
    for (int y = 3; y < 8; y++) begin
      for (int x = ((y == 3) ? 18 : 0); x < 40; x++) begin
        e = '{hc: ((y == 3) ? x - 17 : x), vc: ((y == 3) ? 0 : y - 3), ht: 0, vt: 0,
              lk: 1'b0, ls: 1'b0, fs: 1'b0, er: 1'b0};
        pix(x < 8, y < 3, 0, e);
      end
    end
    for (int r = 0; r < 4; r++) begin
      gen_frame(8, 40, 0, 1'b0, 0, r == 3, -1, (r == 0) ? 0 : 40,
                (r == 0) ? 1 : -1, 40, 0, 0, -1, -1);
      $display("txn %s frame %0d: checks=%0d errors=%0d", phase, r, checks, errors);
    end

    // Line periods alternating 40/41: never leaves horizontal measurement.
    phase = "jitter";
    do_reset();
    for (int r = 0; r < 4; r++) begin
      gen_frame(8, 40, 0, 1'b1, 0, 1'b0, -1, 0, -1, 0, 0, 0, -1, -1);
      $display("txn %s frame %0d: checks=%0d errors=%0d", phase, r, checks, errors);
    end

    // Both syncs held active: one edge at the first sample, then a timeout.
    phase = "stuck_active";
    do_reset();
    for (int k = 0; k < 4100; k++) begin
      e = '{hc: k, vc: 0, ht: 0, vt: 0, lk: 1'b0, ls: 1'b0, fs: 1'b0, er: (k == 4095)};
      pix(1'b1, 1'b1, 0, e);
    end
    $display("txn %s: checks=%0d errors=%0d", phase, checks, errors);

    phase = "drain";
    repeat (3) @(posedge I_clock);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
